bist_response_analyzer: RTL and testbench

- Datapath stage directly downstream of the BIST controller; consumes its init/running/toggle/finish strobes.
- Generates LFSR test patterns for the circuit under test (CUT) and compacts CUT responses in a MISR.
- On finish, compares the signature against a golden value and reports a sticky pass/fail verdict.

---
 rtl/bist_response_analyzer_if.sv | 36 +++
 rtl/bist_response_analyzer.sv | 91 +++++++++
 tb/tb_bist_response_analyzer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bist_response_analyzer_if.sv
// ============================================================================
// Module   : bist_response_analyzer_if
// Purpose  : Strobe, response and verdict bundle between BIST controller/CUT
//            and the response analyzer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bist_response_analyzer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 10
);
  logic             init;
  logic             running;
  logic             toggle;
  logic             finish;
  logic [WIDTH-1:0] cut_out;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] capture_cnt;
  logic             done;
  logic             pass;
  logic             fail;

  modport master (
    output init, running, toggle, finish, cut_out,
    input  pattern, signature, capture_cnt, done, pass, fail
  );

  modport slave (
    input  init, running, toggle, finish, cut_out,
    output pattern, signature, capture_cnt, done, pass, fail
  );
endinterface

`default_nettype wire

// File: rtl/bist_response_analyzer.sv
// ============================================================================
// Module   : bist_response_analyzer
// Purpose  : LFSR pattern generator plus MISR response compactor with a
//            sticky golden-signature pass/fail verdict.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_response_analyzer #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_SEED = 8'h01,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] MISR_POLY = 8'hB8,
  parameter logic [WIDTH-1:0] GOLDEN    = 8'h01,
  parameter int               CNT_W     = 10
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  bist_response_analyzer_if.slave    bus
);

  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_misr;
  logic             r_phase;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;

  logic [WIDTH-1:0] w_lfsr_next;
  logic [WIDTH-1:0] w_misr_next;
  logic             w_capture;
  logic             w_verdict_pass;

  assign w_lfsr_next    = {r_lfsr[WIDTH-2:0], ^(r_lfsr & LFSR_TAPS)};
  assign w_misr_next    = {r_misr[WIDTH-2:0], ^(r_misr & MISR_POLY)} ^ bus.cut_out;
  assign w_capture      = bus.running & r_armed;
  assign w_verdict_pass = r_armed & (r_misr == GOLDEN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr  <= LFSR_SEED;
      r_misr  <= '0;
      r_phase <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (bus.init) begin
      r_lfsr  <= LFSR_SEED;
      r_misr  <= '0;
      r_phase <= 1'b0;
      r_armed <= 1'b1;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (bus.finish) begin
      // A verdict, once latched, is held until the next init or reset.
      if (!r_done) begin
        r_done  <= 1'b1;
        r_pass  <= w_verdict_pass;
        r_fail  <= ~w_verdict_pass;
        r_armed <= 1'b0;
      end
    end else begin
      if (w_capture) begin
        r_lfsr <= w_lfsr_next;
        r_misr <= w_misr_next;
        if (r_cnt != {CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      if (bus.toggle && r_armed) begin
        r_phase <= ~r_phase;
      end
    end
  end

  assign bus.pattern     = r_lfsr ^ {WIDTH{r_phase}};
  assign bus.signature   = r_misr;
  assign bus.capture_cnt = r_cnt;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail        = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_bist_response_analyzer.sv
// ============================================================================
// Module   : tb_bist_response_analyzer
// Purpose  : Directed and randomized checks of the BIST response analyzer
//            against a sequence-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_response_analyzer;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 10;
  localparam logic [7:0] SEED  = 8'h01;
  localparam logic [7:0] TAPS  = 8'hB8;
  localparam logic [7:0] POLY  = 8'hB8;
  localparam logic [7:0] GOLD  = 8'h01;

  logic clk;
  logic reset;

  bist_response_analyzer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  bist_response_analyzer #(
    .WIDTH(WIDTH), .LFSR_SEED(SEED), .LFSR_TAPS(TAPS),
    .MISR_POLY(POLY), .GOLDEN(GOLD), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: the run is described by how many patterns have been
  // consumed and the list of responses captured since init.
  int         m_steps;
  logic [7:0] m_resp[$];
  logic       m_phase, m_armed, m_done, m_pass, m_fail;

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = {v[6:0], 1'($countones(v & TAPS) % 2)};
    return v;
  endfunction

  function automatic logic [7:0] misr_of();
    logic [7:0] s;
    s = 8'h00;
    foreach (m_resp[i]) s = {s[6:0], 1'($countones(s & POLY) % 2)} ^ m_resp[i];
    return s;
  endfunction

  function automatic logic [9:0] cnt_of();
    return (m_resp.size() > 1023) ? 10'h3FF : 10'(m_resp.size());
  endfunction

  task automatic model_clear(input logic armed);
    m_steps = 0;
    m_resp.delete();
    m_phase = 1'b0;
    m_armed = armed;
    m_done  = 1'b0;
    m_pass  = 1'b0;
    m_fail  = 1'b0;
  endtask

  task automatic model_update(input logic rst_n, ini, run, tog, fin, input logic [7:0] cut);
    if (!rst_n)   model_clear(1'b0);
    else if (ini) model_clear(1'b1);
    else if (fin) begin
      if (!m_done) begin
        m_done  = 1'b1;
        m_pass  = m_armed && (misr_of() == GOLD);
        m_fail  = !m_pass;
        m_armed = 1'b0;
      end
    end else begin
      if (m_armed && run) begin
        m_resp.push_back(cut);
        m_steps++;
      end
      if (m_armed && tog) m_phase = !m_phase;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pattern"},   32'(bus.pattern),     32'(lfsr_at(m_steps) ^ {8{m_phase}}));
    chk({tag, "_signature"}, 32'(bus.signature),   32'(misr_of()));
    chk({tag, "_cnt"},       32'(bus.capture_cnt), 32'(cnt_of()));
    chk({tag, "_done"},      32'(bus.done),        32'(m_done));
    chk({tag, "_pass"},      32'(bus.pass),        32'(m_pass));
    chk({tag, "_fail"},      32'(bus.fail),        32'(m_fail));
  endtask

  // One clock: drive inputs away from the edge, advance the model, sample at +1.
  task automatic cyc(input string tag, input logic rst_n, ini, run, tog, fin,
                     input logic [7:0] cut);
    reset       = rst_n;
    bus.init    = ini;
    bus.running = run;
    bus.toggle  = tog;
    bus.finish  = fin;
    bus.cut_out = cut;
    @(posedge clk);
    model_update(rst_n, ini, run, tog, fin, cut);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_clear(1'b0);
    reset = 1'b0;
    bus.init = 1'b0; bus.running = 1'b0; bus.toggle = 1'b0; bus.finish = 1'b0;
    bus.cut_out = 8'h00;
    #2;

    // 1: reset for two cycles, then release
    cyc("rst", 1'b0, 0, 0, 0, 0, 8'h00);
    cyc("rst", 1'b0, 0, 0, 0, 0, 8'h00);
    cyc("idle", 1'b1, 0, 0, 0, 0, 8'h00);
    chk("t1_pattern", 32'(bus.pattern), 32'h01);

    // 6c: running with no init has no effect
    for (int i = 0; i < 3; i++) cyc("noinit_run", 1'b1, 0, 1, 0, 0, 8'h5A);
    chk("t6_noinit_cnt", 32'(bus.capture_cnt), 32'h0);

    // 6a: finish with no prior init gives a fail verdict
    cyc("noinit_fin", 1'b1, 0, 0, 0, 1, 8'h00);
    chk("t6_noinit_fail", 32'(bus.fail), 32'h1);

    // 2: five captures of zero response
    cyc("t2_init", 1'b1, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc("t2_run", 1'b1, 0, 1, 0, 0, 8'h00);
    chk("t2_pattern", 32'(bus.pattern), 32'h23);
    chk("t2_cnt", 32'(bus.capture_cnt), 32'h5);

    // 3: FF, FF folds to the golden signature
    cyc("t3_init", 1'b1, 1, 0, 0, 0, 8'h00);
    cyc("t3_run", 1'b1, 0, 1, 0, 0, 8'hFF);
    cyc("t3_run", 1'b1, 0, 1, 0, 0, 8'hFF);
    chk("t3_sig", 32'(bus.signature), 32'h01);
    cyc("t3_fin", 1'b1, 0, 0, 0, 1, 8'h00);
    chk("t3_pass", 32'(bus.pass), 32'h1);

    // 4: FF, FE misses golden; verdict is sticky
    cyc("t4_init", 1'b1, 1, 0, 0, 0, 8'h00);
    cyc("t4_run", 1'b1, 0, 1, 0, 0, 8'hFF);
    cyc("t4_run", 1'b1, 0, 1, 0, 0, 8'hFE);
    cyc("t4_fin", 1'b1, 0, 0, 0, 1, 8'h00);
    chk("t4_fail", 32'(bus.fail), 32'h1);
    cyc("t4_fin2", 1'b1, 0, 0, 0, 1, 8'h00);
    cyc("t4_run2", 1'b1, 0, 1, 1, 0, 8'h33);
    chk("t4_sig_hold", 32'(bus.signature), 32'h00);

    // 5: polarity toggle, then finish concurrent with running
    cyc("t5_init", 1'b1, 1, 0, 0, 0, 8'h00);
    cyc("t5_run", 1'b1, 0, 1, 0, 0, 8'h12);
    cyc("t5_run", 1'b1, 0, 1, 0, 0, 8'h34);
    cyc("t5_tog", 1'b1, 0, 0, 1, 0, 8'h00);
    chk("t5_inv_pat", 32'(bus.pattern), 32'hFB);
    cyc("t5_run_tog", 1'b1, 0, 1, 1, 0, 8'h56);
    cyc("t5_fin_run", 1'b1, 0, 1, 0, 1, 8'h78);
    chk("t5_cnt", 32'(bus.capture_cnt), 32'h3);

    // 6b: reset mid-run
    cyc("t6_init", 1'b1, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc("t6_run", 1'b1, 0, 1, 0, 0, 8'(i + 7));
    cyc("t6_rst", 1'b0, 0, 1, 1, 1, 8'hAA);
    chk("t6_rst_cnt", 32'(bus.capture_cnt), 32'h0);

    // 6d: init and finish together
    cyc("t6_initfin", 1'b1, 1, 0, 0, 1, 8'h00);
    chk("t6_initfin_done", 32'(bus.done), 32'h0);

    // Randomized traffic with rare init/finish/reset
    for (int i = 0; i < 600; i++) begin
      cyc("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
          1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
          8'($urandom));
      chk("rand_excl", 32'(bus.pass & bus.fail), 32'h0);
    end

    // Capture counter saturation
    cyc("sat_init", 1'b1, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 1030; i++) cyc("sat", 1'b1, 0, 1, 0, 0, 8'($urandom));
    chk("sat_cnt", 32'(bus.capture_cnt), 32'h3FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
